// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter serialising 32-bit requester words onto a UART byte transmitter
// Optional per-frame source header byte enabled by defining UART_ARB_HEADER_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int SRC_W   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic                   tx_start,
    output logic [7:0]             tx_byte,
    input  logic                   tx_done,
    output logic                   busy,
    output logic [SRC_W-1:0]       cur_src
);

`ifdef UART_ARB_HEADER_EN
    localparam int SHIFT_W = 40;
`else
    localparam int SHIFT_W = 32;
`endif
    localparam int LAST_BYTE = SHIFT_W / 8 - 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [SHIFT_W-1:0] r_shift;
    logic [2:0]         r_byte_cnt;
    logic [SRC_W-1:0]   r_grant;
    logic [SRC_W-1:0]   r_cur_src;
    logic [SRC_W-1:0]   r_last_grant;
    logic [SRC_W-1:0]   w_rr_grant;
    logic               w_rr_found;
    logic               w_grant_valid;
    logic [31:0]        w_word;
    logic               w_last_byte;

    // Search starts one past the previous owner so every requester gets a turn.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_grant = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_rr_found && req_valid[(int'(r_last_grant) + k) % NUM_REQ]) begin
                w_rr_found = 1'b1;
                w_rr_grant = SRC_W'((int'(r_last_grant) + k) % NUM_REQ);
            end
        end
    end

    assign w_grant_valid = req_valid[r_grant];
    assign w_word        = req_data[32*int'(r_grant) +: 32];
    assign w_last_byte   = (r_byte_cnt == 3'(LAST_BYTE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_rr_found) w_next = S_LOAD;
            // A requester that dropped its request after winning is treated as withdrawn.
            S_LOAD:  w_next = w_grant_valid ? S_SEND : S_IDLE;
            S_SEND:  w_next = S_WAIT;
            S_WAIT:  if (tx_done) w_next = w_last_byte ? S_IDLE : S_SEND;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift      <= '0;
            r_byte_cnt   <= '0;
            r_grant      <= '0;
            r_cur_src    <= '0;
            r_last_grant <= SRC_W'(NUM_REQ - 1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rr_found) r_grant <= w_rr_grant;
                end
                S_LOAD: begin
                    if (w_grant_valid) begin
`ifdef UART_ARB_HEADER_EN
                        r_shift <= {8'hA0 | 8'(r_grant), w_word};
`else
                        r_shift <= w_word;
`endif
                        r_byte_cnt <= '0;
                        r_cur_src  <= r_grant;
                    end
                end
                S_WAIT: begin
                    if (tx_done) begin
                        if (w_last_byte) begin
                            r_last_grant <= r_cur_src;
                        end else begin
                            r_shift    <= r_shift << 8;
                            r_byte_cnt <= r_byte_cnt + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy     = (r_state != S_IDLE);
        tx_start = (r_state == S_SEND);
        tx_byte  = r_shift[SHIFT_W-1 -: 8];
        cur_src  = r_cur_src;
        req_ack  = '0;
        if (r_state == S_LOAD && w_grant_valid) req_ack[r_grant] = 1'b1;
    end

endmodule
